player_vert_physics: RTL and testbench
======================================

PLAYER_VERT_PHYSICS -- requirements
Module: player_vert_physics

Interface
REQ-001 Parameter HEIGHT, default 30, sprite half-height; the sprite bottom is at y_pos + 2*HEIGHT.
REQ-002 Parameter JUMP_VEL, default -12, signed vertical velocity loaded on a jump.
REQ-003 Parameter GRAVITY, default 1, velocity increment per frame.
REQ-004 Parameter MAX_FALL, default 8, downward velocity clamp.
REQ-005 Parameter RESPAWN_FRAMES, default 60, frames held in respawn.
REQ-006 clk  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-009 jump_btn  in  1  synchronous level from the controller.
REQ-010 touching_plt  in  3  per-platform landing flags from the three platform collision checkers, which are evaluated on y_pos/next_y.
REQ-011 y_pos  out  11 signed  registered sprite top.
REQ-012 next_y  out  11 signed  combinational proposed position for the collision checkers.
REQ-013 vel_y  out  6 signed  registered velocity; positive is downward.
REQ-014 grounded  out  1  high in GROUNDED.
REQ-015 ko_pulse  out  1  one-cycle pulse on knockout.

Function
REQ-016 States SHALL be GROUNDED, AIRBORNE and RESPAWN, and all state and register updates SHALL occur only on cycles with frame_tick=1, except the jump latch.
REQ-017 next_y SHALL be y_pos+vel_y in AIRBORNE, y_pos+1 in GROUNDED (support probe), and y_pos in RESPAWN, with the sum saturated to the 11-bit signed range.
REQ-018 A rising edge of jump_btn, detected with a registered previous value, SHALL set jump_pending; jump_pending SHALL clear at the next frame_tick whether or not the jump is consumed.
REQ-019 In AIRBORNE on tick with vel_y>=0 and touching_plt!=0: the lowest set index i SHALL win; y_pos <= PLT_Y[i]-2*HEIGHT, vel_y <= 0, jumps_left <= 2, state GROUNDED.
REQ-020 In AIRBORNE on tick otherwise: y_pos <= next_y and vel_y <= min(vel_y+GRAVITY, MAX_FALL); if jump_pending and jumps_left>0, then vel_y <= JUMP_VEL and jumps_left decrements, with the jump overriding the gravity update.
REQ-021 While vel_y<0 (rising), touching_plt SHALL be ignored, so platforms are passable from below.
REQ-022 In GROUNDED on tick: if jump_pending, then vel_y <= JUMP_VEL, jumps_left <= 1, state AIRBORNE; else if touching_plt==0 (walked off an edge), then vel_y <= 0, jumps_left <= 1, state AIRBORNE; else y_pos is held.
REQ-023 A jump SHALL take priority over walk-off when both occur on the same tick.
REQ-024 From GROUNDED or AIRBORNE on tick, if y_pos > KO_Y, then RESPAWN SHALL be entered, ko_pulse SHALL assert for exactly one clk, y_pos <= SPAWN_Y, vel_y <= 0, and the frame counter SHALL load RESPAWN_FRAMES-1.
REQ-025 KO_Y SHALL have priority over landing and jump.
REQ-026 In RESPAWN, the counter SHALL decrement per tick, jump_pending SHALL be discarded, and at count 0 the block SHALL enter AIRBORNE with jumps_left=2.
REQ-027 jumps_left SHALL be a 2-bit counter saturating at 0.

Reset
REQ-028 While rst_n=0, and asynchronously at any point including mid-jump or mid-respawn: state AIRBORNE, y_pos=SPAWN_Y, vel_y=0, jumps_left=2, jump_pending=0, prev jump_btn=0, counter=0, ko_pulse=0, grounded=0.
REQ-029 The first update after rst_n deasserts SHALL occur at the first frame_tick.

Structure
REQ-030 A shared physics package SHALL hold PLT_Y[0:2] (platform 3 top = 215), SPAWN_Y=100, KO_Y=480, the state enum, and the velocity width.
REQ-031 Three platform collision checker instances SHALL live in the parent, not in this block; an optional sub-module jump_edge_latch SHALL hold the edge detect and pending flag.

Verification
REQ-032 Reset, then ticks with touching_plt=0 -> y_pos: 100, 100, 101, 103, 106...; vel_y: 0, 1, 2, 3... clamping at 8.
REQ-033 AIRBORNE with vel_y=5 and touching_plt=3'b100 on a tick -> y_pos=155, vel_y=0, grounded=1.
REQ-034 GROUNDED at y=155, jump_btn pulse between ticks -> next tick vel_y=-12; following tick y_pos=143, vel_y=-11; a second press gives vel_y=-12; a third press is ignored.
REQ-035 GROUNDED at 155 with touching_plt dropping to 0 -> AIRBORNE with vel_y=0 and jumps_left=1; jump and drop on the same tick -> jump is taken.
REQ-036 Fall to y_pos=481 -> ko_pulse for 1 clk, y_pos=100, 60 ticks in RESPAWN ignoring jump_btn, then AIRBORNE; rst_n pulsed mid-RESPAWN -> reset values immediately.

Source files
------------

// File: rtl/player_vert_physics_pkg.sv
// Shared vertical-physics constants, state encoding and the saturating position adder.
package player_vert_physics_pkg;

    localparam int Y_W   = 11;
    localparam int VEL_W = 6;

    localparam logic signed [Y_W-1:0] SPAWN_Y = 11'sd100;
    localparam logic signed [Y_W-1:0] KO_Y    = 11'sd480;
    localparam logic signed [Y_W-1:0] PLT_Y [0:2] = '{11'sd400, 11'sd300, 11'sd215};

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        AIRBORNE = 2'd1,
        RESPAWN  = 2'd2
    } phys_state_t;

    // Position + velocity, clipped to the signed position range instead of wrapping.
    function automatic logic signed [Y_W-1:0] sat_add(
        input logic signed [Y_W-1:0]   a,
        input logic signed [VEL_W-1:0] b
    );
        logic signed [Y_W:0] s;
        s = (Y_W+1)'(a) + (Y_W+1)'(b);
        if (s[Y_W] != s[Y_W-1])
            return s[Y_W] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
        return s[Y_W-1:0];
    endfunction

endpackage

// File: rtl/player_vert_physics_if.sv
// Controller/collision inputs and position/velocity outputs of the vertical physics block.
interface player_vert_physics_if;
    import player_vert_physics_pkg::*;

    logic                    frame_tick;
    logic                    jump_btn;
    logic [2:0]              touching_plt;
    logic signed [Y_W-1:0]   y_pos;
    logic signed [Y_W-1:0]   next_y;
    logic signed [VEL_W-1:0] vel_y;
    logic                    grounded;
    logic                    ko_pulse;

    modport master (
        output frame_tick, jump_btn, touching_plt,
        input  y_pos, next_y, vel_y, grounded, ko_pulse
    );

    modport slave (
        input  frame_tick, jump_btn, touching_plt,
        output y_pos, next_y, vel_y, grounded, ko_pulse
    );

endinterface

// File: rtl/player_vert_physics_jump_edge_latch.sv
// Registers jump_btn rising edges into a pending flag that lives until the next frame tick.
module jump_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic jump_btn,
    output logic jump_pending
);

    logic prev_btn;

    // A press landing on the tick cycle itself is kept for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_btn     <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            prev_btn     <= jump_btn;
            jump_pending <= (jump_btn & ~prev_btn) | (jump_pending & ~frame_tick);
        end
    end

endmodule

// File: rtl/player_vert_physics.sv
// Per-frame vertical motion: gravity, double jump, platform landing and knockout respawn.
module player_vert_physics
    import player_vert_physics_pkg::*;
#(
    parameter int HEIGHT         = 30,
    parameter int JUMP_VEL       = -12,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL       = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    player_vert_physics_if.slave bus
);

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

    phys_state_t             state, state_n;
    logic signed [Y_W-1:0]   y_q, y_n, next_y_c, land_y;
    logic signed [VEL_W-1:0] vel_q, vel_n, vel_grav;
    logic signed [VEL_W+1:0] vel_inc;
    logic [1:0]              jl_q, jl_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic                    ko_q, ko_n;
    logic                    jump_pending;

    jump_edge_latch u_jump (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (bus.frame_tick),
        .jump_btn     (bus.jump_btn),
        .jump_pending (jump_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AIRBORNE;
            y_q   <= SPAWN_Y;
            vel_q <= '0;
            jl_q  <= 2'd2;
            cnt_q <= '0;
            ko_q  <= 1'b0;
        end else begin
            state <= state_n;
            y_q   <= y_n;
            vel_q <= vel_n;
            jl_q  <= jl_n;
            cnt_q <= cnt_n;
            ko_q  <= ko_n;
        end
    end

    always_comb begin
        next_y_c = y_q;
        case (state)
            AIRBORNE: next_y_c = sat_add(y_q, vel_q);
            GROUNDED: next_y_c = sat_add(y_q, 6'sd1);
            default:  next_y_c = y_q;
        endcase

        vel_inc  = (VEL_W+2)'(vel_q) + (VEL_W+2)'(GRAVITY);
        vel_grav = (vel_inc > (VEL_W+2)'(MAX_FALL)) ? VEL_W'(MAX_FALL) : vel_inc[VEL_W-1:0];

        // Lowest-numbered touching platform wins.
        land_y = PLT_Y[2] - 11'(2 * HEIGHT);
        if (bus.touching_plt[0])      land_y = PLT_Y[0] - 11'(2 * HEIGHT);
        else if (bus.touching_plt[1]) land_y = PLT_Y[1] - 11'(2 * HEIGHT);
    end

    always_comb begin
        state_n = state;
        y_n     = y_q;
        vel_n   = vel_q;
        jl_n    = jl_q;
        cnt_n   = cnt_q;
        ko_n    = 1'b0;
        if (bus.frame_tick) begin
            if (state != RESPAWN && y_q > KO_Y) begin
                state_n = RESPAWN;
                ko_n    = 1'b1;
                y_n     = SPAWN_Y;
                vel_n   = '0;
                cnt_n   = CNT_W'(RESPAWN_FRAMES - 1);
            end else begin
                case (state)
                    GROUNDED: begin
                        if (jump_pending) begin
                            vel_n   = VEL_W'(JUMP_VEL);
                            jl_n    = 2'd1;
                            state_n = AIRBORNE;
                        end else if (bus.touching_plt == 3'b000) begin
                            vel_n   = '0;
                            jl_n    = 2'd1;
                            state_n = AIRBORNE;
                        end
                    end
                    AIRBORNE: begin
                        // Platforms only catch a sprite that is not rising.
                        if (!vel_q[VEL_W-1] && bus.touching_plt != 3'b000) begin
                            y_n     = land_y;
                            vel_n   = '0;
                            jl_n    = 2'd2;
                            state_n = GROUNDED;
                        end else begin
                            y_n = next_y_c;
                            if (jump_pending && jl_q != 2'd0) begin
                                vel_n = VEL_W'(JUMP_VEL);
                                jl_n  = jl_q - 2'd1;
                            end else begin
                                vel_n = vel_grav;
                            end
                        end
                    end
                    default: begin
                        if (cnt_q == '0) begin
                            state_n = AIRBORNE;
                            jl_n    = 2'd2;
                        end else begin
                            cnt_n = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.y_pos    = y_q;
    assign bus.next_y   = next_y_c;
    assign bus.vel_y    = vel_q;
    assign bus.grounded = (state == GROUNDED);
    assign bus.ko_pulse = ko_q;

endmodule

// File: tb/tb_player_vert_physics.sv
// Directed-vector bench for player_vert_physics with hand-computed expectations.
module tb_player_vert_physics;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    player_vert_physics_if bus();

    player_vert_physics dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic do_tick;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic press;
        @(negedge clk);
        bus.jump_btn = 1'b1;
        @(negedge clk);
        bus.jump_btn = 1'b0;
    endtask

    task automatic apply_reset;
        rst_n            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.jump_btn     = 1'b0;
        bus.touching_plt = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reset, fall five frames (vel 5, y 110), then land on platform index 2 at y 155.
    task automatic land_155;
        apply_reset();
        repeat (5) do_tick();
        bus.touching_plt = 3'b100;
        do_tick();
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.jump_btn     = 1'b0;
        bus.touching_plt = 3'b000;
        repeat (2) @(negedge clk);
        checks++; if (bus.y_pos !== 11'sd100) begin errors++; $display("FAIL reset_y: got %0d want 100", bus.y_pos); end
        checks++; if (bus.vel_y !== 6'sd0) begin errors++; $display("FAIL reset_vel: got %0d want 0", bus.vel_y); end
        checks++; if (bus.grounded !== 1'b0 || bus.ko_pulse !== 1'b0) begin errors++; $display("FAIL reset_flags: got g=%0b ko=%0b want 0 0", bus.grounded, bus.ko_pulse); end
        checks++; if (bus.next_y !== 11'sd100) begin errors++; $display("FAIL reset_next_y: got %0d want 100", bus.next_y); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.vel_y !== 6'sd0 || bus.y_pos !== 11'sd100) begin errors++; $display("FAIL no_tick_hold: got y=%0d v=%0d want 100 0", bus.y_pos, bus.vel_y); end
    endtask

    task automatic test_gravity;
        logic signed [10:0] exp_y [0:3];
        logic signed [5:0]  exp_v [0:3];
        exp_y = '{11'sd100, 11'sd101, 11'sd103, 11'sd106};
        exp_v = '{6'sd1, 6'sd2, 6'sd3, 6'sd4};
        for (int i = 0; i < 4; i++) begin
            do_tick();
            checks++; if (bus.y_pos !== exp_y[i] || bus.vel_y !== exp_v[i]) begin
                errors++; $display("FAIL gravity_%0d: got y=%0d v=%0d want y=%0d v=%0d", i, bus.y_pos, bus.vel_y, exp_y[i], exp_v[i]);
            end
        end
        repeat (6) do_tick();
        checks++; if (bus.vel_y !== 6'sd8 || bus.y_pos !== 11'sd144) begin errors++; $display("FAIL fall_clamp: got y=%0d v=%0d want 144 8", bus.y_pos, bus.vel_y); end
        do_tick();
        checks++; if (bus.vel_y !== 6'sd8 || bus.y_pos !== 11'sd152) begin errors++; $display("FAIL fall_clamp_hold: got y=%0d v=%0d want 152 8", bus.y_pos, bus.vel_y); end
    endtask

    task automatic test_landing;
        land_155();
        checks++; if (bus.y_pos !== 11'sd155 || bus.vel_y !== 6'sd0 || bus.grounded !== 1'b1) begin
            errors++; $display("FAIL land: got y=%0d v=%0d g=%0b want 155 0 1", bus.y_pos, bus.vel_y, bus.grounded);
        end
        checks++; if (bus.next_y !== 11'sd156) begin errors++; $display("FAIL probe_next_y: got %0d want 156", bus.next_y); end
        do_tick();
        checks++; if (bus.y_pos !== 11'sd155 || bus.grounded !== 1'b1) begin errors++; $display("FAIL ground_hold: got y=%0d g=%0b want 155 1", bus.y_pos, bus.grounded); end
        apply_reset();
        repeat (5) do_tick();
        bus.touching_plt = 3'b110;
        do_tick();
        checks++; if (bus.y_pos !== 11'sd240 || bus.grounded !== 1'b1) begin errors++; $display("FAIL land_lowest_idx: got y=%0d g=%0b want 240 1", bus.y_pos, bus.grounded); end
    endtask

    task automatic test_jump;
        land_155();
        press();
        do_tick();
        checks++; if (bus.vel_y !== -6'sd12 || bus.y_pos !== 11'sd155 || bus.grounded !== 1'b0) begin
            errors++; $display("FAIL jump1: got y=%0d v=%0d g=%0b want 155 -12 0", bus.y_pos, bus.vel_y, bus.grounded);
        end
        do_tick();
        checks++; if (bus.y_pos !== 11'sd143 || bus.vel_y !== -6'sd11) begin errors++; $display("FAIL rise_pass_through: got y=%0d v=%0d want 143 -11", bus.y_pos, bus.vel_y); end
        press();
        do_tick();
        checks++; if (bus.y_pos !== 11'sd132 || bus.vel_y !== -6'sd12) begin errors++; $display("FAIL jump2: got y=%0d v=%0d want 132 -12", bus.y_pos, bus.vel_y); end
        press();
        do_tick();
        checks++; if (bus.y_pos !== 11'sd120 || bus.vel_y !== -6'sd11) begin errors++; $display("FAIL jump3_ignored: got y=%0d v=%0d want 120 -11", bus.y_pos, bus.vel_y); end
    endtask

    task automatic test_walk_off;
        land_155();
        bus.touching_plt = 3'b000;
        do_tick();
        checks++; if (bus.grounded !== 1'b0 || bus.vel_y !== 6'sd0 || bus.y_pos !== 11'sd155) begin
            errors++; $display("FAIL walk_off: got y=%0d v=%0d g=%0b want 155 0 0", bus.y_pos, bus.vel_y, bus.grounded);
        end
        press();
        do_tick();
        checks++; if (bus.vel_y !== -6'sd12 || bus.y_pos !== 11'sd155) begin errors++; $display("FAIL walk_off_air_jump: got y=%0d v=%0d want 155 -12", bus.y_pos, bus.vel_y); end
        press();
        do_tick();
        checks++; if (bus.vel_y !== -6'sd11 || bus.y_pos !== 11'sd143) begin errors++; $display("FAIL walk_off_jumps_left: got y=%0d v=%0d want 143 -11", bus.y_pos, bus.vel_y); end
        land_155();
        press();
        bus.touching_plt = 3'b000;
        do_tick();
        checks++; if (bus.vel_y !== -6'sd12 || bus.grounded !== 1'b0) begin errors++; $display("FAIL jump_over_drop: got v=%0d g=%0b want -12 0", bus.vel_y, bus.grounded); end
    endtask

    task automatic fall_to_ko;
        int n;
        apply_reset();
        n = 0;
        while (bus.y_pos <= 11'sd480 && n < 100) begin
            do_tick();
            n++;
        end
        checks++; if (bus.y_pos !== 11'sd488) begin errors++; $display("FAIL fall_to_ko_y: got %0d want 488 after %0d ticks", bus.y_pos, n); end
    endtask

    task automatic test_ko_respawn;
        fall_to_ko();
        do_tick();
        checks++; if (bus.ko_pulse !== 1'b1 || bus.y_pos !== 11'sd100 || bus.vel_y !== 6'sd0) begin
            errors++; $display("FAIL ko_enter: got ko=%0b y=%0d v=%0d want 1 100 0", bus.ko_pulse, bus.y_pos, bus.vel_y);
        end
        @(negedge clk);
        checks++; if (bus.ko_pulse !== 1'b0) begin errors++; $display("FAIL ko_one_clk: got %0b want 0", bus.ko_pulse); end
        for (int i = 0; i < 60; i++) begin
            press();
            do_tick();
        end
        checks++; if (bus.vel_y !== 6'sd0 || bus.y_pos !== 11'sd100 || bus.grounded !== 1'b0) begin
            errors++; $display("FAIL respawn_hold: got y=%0d v=%0d g=%0b want 100 0 0", bus.y_pos, bus.vel_y, bus.grounded);
        end
        do_tick();
        checks++; if (bus.vel_y !== 6'sd1 || bus.y_pos !== 11'sd100) begin errors++; $display("FAIL respawn_exit: got y=%0d v=%0d want 100 1", bus.y_pos, bus.vel_y); end
        press();
        do_tick();
        checks++; if (bus.vel_y !== -6'sd12 || bus.y_pos !== 11'sd101) begin errors++; $display("FAIL respawn_jump: got y=%0d v=%0d want 101 -12", bus.y_pos, bus.vel_y); end
        press();
        do_tick();
        checks++; if (bus.vel_y !== -6'sd12 || bus.y_pos !== 11'sd89) begin errors++; $display("FAIL respawn_double_jump: got y=%0d v=%0d want 89 -12", bus.y_pos, bus.vel_y); end
    endtask

    task automatic test_reset_mid;
        land_155();
        press();
        do_tick();
        do_tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.y_pos !== 11'sd100 || bus.vel_y !== 6'sd0 || bus.grounded !== 1'b0) begin
            errors++; $display("FAIL async_reset_jump: got y=%0d v=%0d g=%0b want 100 0 0", bus.y_pos, bus.vel_y, bus.grounded);
        end
        fall_to_ko();
        do_tick();
        repeat (5) do_tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ko_pulse !== 1'b0 || bus.y_pos !== 11'sd100 || bus.vel_y !== 6'sd0) begin
            errors++; $display("FAIL async_reset_respawn: got ko=%0b y=%0d v=%0d want 0 100 0", bus.ko_pulse, bus.y_pos, bus.vel_y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_tick();
        checks++; if (bus.vel_y !== 6'sd1 || bus.y_pos !== 11'sd100) begin errors++; $display("FAIL post_reset_airborne: got y=%0d v=%0d want 100 1", bus.y_pos, bus.vel_y); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.jump_btn     = 1'b0;
        bus.touching_plt = 3'b000;
        test_reset();
        test_gravity();
        test_landing();
        test_jump();
        test_walk_off();
        test_ko_respawn();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
